// File: rtl/fetch_issue.sv
// Fetch/issue: PC + imem req/ack, holds one instruction for decode; ack->valid 1 cycle, handshake->next req 1 cycle.
// Backpressure: stays in HOLD (no fetch) while issue_ready=0; redirects mask issue_valid in their cycle.
module fetch_issue #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [11:0]     imem_data,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [3:0]      opcode,
  output logic            imm_flag,
  output logic [1:0]      format,
  output logic [4:0]      operand,
  output logic [PC_W-1:0] issue_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic            halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_e;

  localparam logic [3:0] OP_HALT = 4'b1110;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] issue_pc_q, issue_pc_d;
  logic [11:0]     instr_q, instr_d;
  logic            drop_q, drop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      issue_pc_q <= '0;
      instr_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      issue_pc_q <= issue_pc_d;
      instr_q    <= instr_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    issue_pc_d  = issue_pc_q;
    instr_d     = instr_q;
    drop_d      = drop_q;
    imem_req    = 1'b0;
    issue_valid = 1'b0;
    halted      = 1'b0;

    case (state_q)
      IDLE: begin
        pc_d    = redirect_valid ? redirect_target : pc_q;
        addr_d  = pc_d;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (drop_q || redirect_valid) begin
            // Stale data: re-request immediately at the latest target.
            pc_d   = redirect_valid ? redirect_target : pc_q;
            addr_d = pc_d;
            drop_d = 1'b0;
          end else begin
            instr_d    = imem_data;
            issue_pc_d = addr_q;
            pc_d       = addr_q + PC_W'(1);
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          // The address must stay put until ack, so only remember the target.
          pc_d   = redirect_target;
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        issue_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_d    = redirect_target;
          addr_d  = redirect_target;
          state_d = FETCH;
        end else if (issue_ready) begin
          if (instr_q[11:8] == OP_HALT) begin
            state_d = HALT;
          end else begin
            addr_d  = pc_q;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_addr = addr_q;
  assign opcode    = instr_q[11:8];
  assign imm_flag  = instr_q[7];
  assign format    = instr_q[6:5];
  assign operand   = instr_q[4:0];
  assign issue_pc  = issue_pc_q;

endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: behavioural instruction memory with programmable latency and an issue scoreboard.
module tb_fetch_issue;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [11:0]     imem_data;
  logic            issue_valid;
  logic            issue_ready;
  logic [3:0]      opcode;
  logic            imm_flag;
  logic [1:0]      format;
  logic [4:0]      operand;
  logic [PC_W-1:0] issue_pc;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            halted;

  fetch_issue #(.PC_W(PC_W), .RESET_PC(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .imm_flag(imm_flag), .format(format), .operand(operand),
    .issue_pc(issue_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory: acks after lat wait cycles of a continuously held request.
  logic [11:0] mem [0:255];
  int lat;
  int cnt;
  assign imem_ack  = imem_req && (cnt == lat);
  assign imem_data = mem[imem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entry: {pc[7:0], instruction[11:0]}
  logic [19:0] exp_q [$];
  logic [19:0] mon_e;
  int cyc = 0;
  int last_hs = 0;
  logic spacing_en;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && redirect_valid) check("valid_masked", issue_valid, 0);
    if (rst_n && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_issue_pc", issue_pc, 32'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_pc", issue_pc, mon_e[19:12]);
        check("opcode", opcode, mon_e[11:8]);
        check("imm_flag", imm_flag, mon_e[7]);
        check("format", format, mon_e[6:5]);
        check("operand", operand, mon_e[4:0]);
      end
      if (spacing_en) check("hs_spacing", cyc - last_hs, 2);
      last_hs = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a);
    exp_q.push_back({a, mem[a]});
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!issue_valid && n < 50) begin
      tick();
      n++;
    end
    if (!issue_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic issue_one();
    wait_valid();
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 8'hFF);
    check({tag, "_valid"}, issue_valid, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_fields"}, {opcode, imm_flag, format, operand}, 0);
    check({tag, "_issue_pc"}, issue_pc, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    issue_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    lat = 0;
    spacing_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 12'(i * 7 + 1);
    mem[8'hFF] = 12'h100;
    mem[0] = 12'h700;
    mem[1] = 12'h812;
    mem[2] = 12'h9A0;
    mem[3] = 12'h3C1;

    repeat (2) tick();
    check_reset("rst");
    rst_n = 1'b1;
    #1 check("idle_no_req", imem_req, 0);
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 8'hFF);

    // Sequential fetch across the 0xFF -> 0x00 wrap, zero-wait memory.
    push(8'hFF); push(8'h00); push(8'h01); push(8'h02);
    issue_one();
    spacing_en = 1'b1;
    repeat (3) issue_one();
    spacing_en = 1'b0;

    // Backpressure on the instruction at 3.
    wait_valid();
    check("hold_pc", issue_pc, 3);
    repeat (5) begin
      tick();
      check("bp_valid", issue_valid, 1);
      check("bp_no_req", imem_req, 0);
      check("bp_fields", {opcode, imm_flag, format, operand}, 12'h3C1);
      check("bp_pc", issue_pc, 3);
    end

    // Redirect in HOLD; ready is high but nothing may issue.
    redirect_valid = 1'b1;
    redirect_target = 8'h40;
    issue_ready = 1'b1;
    #1 check("redir_hold_valid", issue_valid, 0);
    tick();
    redirect_valid = 1'b0;
    issue_ready = 1'b0;
    check("redir_hold_req", imem_req, 1);
    check("redir_hold_addr", imem_addr, 8'h40);
    push(8'h40);
    issue_one();

    // Redirect in FETCH: slow request to 0x05, redirected to 0x20 while waiting.
    wait_valid();
    check("pc_after_40", issue_pc, 8'h41);
    lat = 3;
    redirect_valid = 1'b1;
    redirect_target = 8'h05;
    tick();
    check("fetch05_addr", imem_addr, 8'h05);
    redirect_target = 8'h20;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!imem_ack && n < 20) begin
      check("fetch_addr_stable", imem_addr, 8'h05);
      tick();
      n++;
    end
    check("ack_seen", imem_ack, 1);
    check("ack_addr", imem_addr, 8'h05);
    tick();
    lat = 5;
    check("refetch_req", imem_req, 1);
    check("refetch_addr", imem_addr, 8'h20);
    push(8'h20);
    issue_one();

    // Reset while the request to 0x21 is waiting.
    tick();
    check("midfetch_req", imem_req, 1);
    check("midfetch_addr", imem_addr, 8'h21);
    rst_n = 1'b0;
    #1 check_reset("midfetch");
    mem[2] = 12'hE00;
    tick();
    rst_n = 1'b1;
    lat = 0;
    tick();
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 8'hFF);

    // HALT at address 2.
    push(8'hFF); push(8'h00); push(8'h01); push(8'h02);
    repeat (4) issue_one();
    check("halted", halted, 1);
    check("halt_no_req", imem_req, 0);
    check("halt_no_valid", issue_valid, 0);
    redirect_target = 8'h10;
    repeat (4) begin
      redirect_valid = 1'b1;
      tick();
      check("halt_redir_req", imem_req, 0);
      check("halt_redir_halted", halted, 1);
    end
    redirect_valid = 1'b0;
    tick();
    check("halt_final_req", imem_req, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_issue.md
# fetch_issue

Instruction fetch and issue unit: the producer side of the instruction decoder. It holds the program counter, reads 12-bit instructions from instruction memory over a req/ack handshake, and splits each one into the `opcode`, `imm_flag` and `format` fields the decoder consumes. It presents these fields to the decode stage over a valid/ready handshake. It accepts redirects from branch/jump resolution and stops fetching after issuing HALT.

## Interface
- `PC_W`, default 8: program counter and instruction address width.
- `RESET_PC`, default 0: first fetch address after reset.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `imem_req` output 1: fetch request; held high until `imem_ack`.
- `imem_addr` output PC_W: fetch address; stable while `imem_req` is high.
- `imem_ack` input 1: `imem_data` is valid this cycle; ends the request.
- `imem_data` input 12: instruction word. `[11:8]` opcode, `[7]` imm_flag, `[6:5]` format, `[4:0]` operand.
- `issue_valid` output 1: an instruction is offered to decode.
- `issue_ready` input 1: decode accepts the instruction.
- `opcode` output 4, `imm_flag` output 1, `format` output 2, `operand` output 5: fields of the held instruction.
- `issue_pc` output PC_W: address of the held instruction.
- `redirect_valid` input 1: the next fetch must come from `redirect_target`.
- `redirect_target` input PC_W: redirect address.
- `halted` output 1: a HALT instruction (opcode 4'b1110) has been issued.

## Operation
- States:
  - IDLE: entered only from reset.
  - FETCH: request outstanding.
  - HOLD: instruction latched and offered to decode.
  - HALT: stopped.
- IDLE → FETCH unconditionally on the first clock after reset deassertion.
- FETCH:
  - `imem_req`=1 with `imem_addr`=pc.
  - On `imem_ack`: latch `imem_data`, set `issue_pc`=pc, set pc←pc+1 (mod 2^PC_W, so 2^PC_W−1 wraps to 0), go to HOLD.
- HOLD:
  - `issue_valid`=1 and all field outputs are stable.
  - When `issue_valid`&`issue_ready`: if the opcode is 4'b1110, go to HALT; otherwise go to FETCH.
- HALT:
  - `imem_req`=0, `issue_valid`=0, `halted`=1.
  - `redirect_valid` is ignored.
  - Only reset exits HALT.
- Redirect in HOLD: drop the held instruction, set pc←`redirect_target`, go to FETCH.
- Redirect in FETCH:
  - Set pc←`redirect_target` and set the `drop` flag.
  - `imem_req` and `imem_addr` stay unchanged until `imem_ack`, because the memory contract requires a stable address.
  - The acked data is discarded. The next cycle issues a fresh request at `redirect_target`.
  - A redirect arriving in the same cycle as `imem_ack` discards that data in the same way.
- Redirect in IDLE: only updates pc.
- Masking: `issue_valid` is combinationally forced to 0 in any cycle where `redirect_valid`=1. No handshake can complete in a redirect cycle.
- A later redirect overrides an earlier one that has not yet been acted on. The last target wins.
- At most one instruction is in flight at any time.
- Field outputs are don't-care when `issue_valid`=0, but they are held stable rather than toggling.

## Timing
- Reset values:
  - state IDLE, pc=`RESET_PC`, `drop`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `issue_valid`=0, `halted`=0.
  - `opcode`, `imm_flag`, `format`, `operand` = 0, and `issue_pc`=0.
- First `imem_req` is high 1 cycle after `rst_n` rises.
- `imem_ack` in cycle k gives `issue_valid` high in cycle k+1.
- Handshake in cycle m gives the next `imem_req` high in cycle m+1.
- Peak throughput with a zero-wait memory is 1 instruction per 2 cycles.
- Redirect in cycle r while in HOLD gives `imem_req` at `redirect_target` in cycle r+1.
- Redirect in FETCH: the request at the target starts the cycle after the pending ack.
- `halted` rises the cycle after the HALT handshake.
- Asserting `rst_n`=0 mid-request aborts immediately. Any late `imem_ack` after reset is the memory's responsibility.

## Test plan
- Sequential fetch:
  - Stimulus: reset, RESET_PC=0, memory ack in the same cycle as req, words 0x700, 0x812, 0x9A0 at addresses 0–2, `issue_ready`=1.
  - Required response: issue opcodes 7, 8, 9 with `issue_pc` 0, 1, 2 in consecutive 2-cycle slots. `imm_flag`=1 for 0x9A0.
- Backpressure:
  - Stimulus: hold `issue_ready`=0 for 5 cycles in HOLD.
  - Required response: `issue_valid` and the fields stay stable, and there is no `imem_req`.
- Redirect in HOLD:
  - Stimulus: in HOLD with `issue_pc`=3, pulse `redirect_valid` with target 0x40.
  - Required response: `issue_valid`=0 that cycle, and the next `imem_addr`=0x40.
- Redirect in FETCH:
  - Stimulus: redirect to 0x20 while a req to 0x05 is waiting 3 cycles for ack.
  - Required response: `imem_addr` stays 0x05 until ack, the data is dropped, the next request is at 0x20, and no instruction from 0x05 is ever issued.
- HALT:
  - Stimulus: word 0xE00 at address 2.
  - Required response: after its handshake, `halted`=1, and `imem_req` stays 0 thereafter even when `redirect_valid` is pulsed.
- Wrap and reset:
  - Stimulus: PC_W=8 with RESET_PC=0xFF, then assert `rst_n` mid-FETCH.
  - Required response: the fetch after 0xFF is at 0x00. After the mid-FETCH reset, all outputs show their reset values immediately and fetch restarts at 0xFF.
